// File: rtl/gbf_fill_pkg.sv
// Shared types and helpers for the GBF fill controller and its address counter.
package gbf_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        RECV,
        DONE
    } fill_state_t;

    localparam int unsigned DEF_DEPTH     = 128;
    localparam int unsigned DEF_BURST_LEN = 32;
    localparam int unsigned ADDR_W        = $clog2(DEF_DEPTH);
    localparam int unsigned LEN_W         = $clog2(DEF_BURST_LEN) + 1;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/gbf_addr_wrap.sv
// Modulo-DEPTH incrementing address counter with synchronous clear and enable.
// Usable on either the write or the read side of a GBF bank.
module gbf_addr_wrap
    import gbf_fill_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(DEPTH)-1:0] addr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Advance one slot per enabled cycle, folding DEPTH-1 back to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en) begin
            addr <= (addr == LAST) ? '0 : addr + AW'(1);
        end
    end

endmodule

// File: rtl/gbf_fill_ctrl.sv
// GBF fill controller: requests DMA bursts while the GBF reports space and
// writes returned words into the bank SRAM. WrEn/WrAddr also feed the request
// monitor. Optional build macro GBF_FILL_ERR_EN adds the sticky ErrOvf flag
// for stray DmaVld / DmaAck.
module gbf_fill_ctrl
    import gbf_fill_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned FRAME_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [FRAME_WIDTH-1:0]       FrameWords,
    input  logic                         ReqIn,
    output logic                         DmaReq,
    output logic [$clog2(BURST_LEN):0]   DmaLen,
    input  logic                         DmaAck,
    input  logic                         DmaVld,
    input  logic [DATA_WIDTH-1:0]        DmaData,
    output logic                         WrEn,
    output logic [$clog2(DEPTH)-1:0]     WrAddr,
    output logic [DATA_WIDTH-1:0]        WrData,
    output logic                         Busy,
    output logic                         Done
`ifdef GBF_FILL_ERR_EN
    ,
    output logic                         ErrOvf
`endif
);

    localparam int unsigned LW = $clog2(BURST_LEN) + 1;
    localparam int unsigned FW = FRAME_WIDTH;

    fill_state_t             state;
    logic [FW-1:0]           remaining;
    logic [LW-1:0]           burst_cnt;
    logic                    vld_accept;
    logic                    wr_en_p1;
    logic [DATA_WIDTH-1:0]   wr_data_p1;

    // A DMA word is only taken while a burst is still owed words
    assign vld_accept = DmaVld && (state == RECV) && (burst_cnt != '0);
    assign Busy       = (state != IDLE);
    assign WrEn       = wr_en_p1;
    assign WrData     = wr_data_p1;

    // Frame sequencing: space wait, request handshake, word reception, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            burst_cnt <= '0;
            DmaReq    <= 1'b0;
            DmaLen    <= '0;
            Done      <= 1'b0;
        end else if (Reset) begin
            state     <= IDLE;
            remaining <= '0;
            burst_cnt <= '0;
            DmaReq    <= 1'b0;
            DmaLen    <= '0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        remaining <= FrameWords;
                        state     <= (FrameWords == '0) ? DONE : WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (ReqIn) begin
                        DmaLen <= LW'(min_u(BURST_LEN, 32'(remaining)));
                        DmaReq <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (DmaAck) begin
                        burst_cnt <= DmaLen;
                        DmaReq    <= 1'b0;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (vld_accept) begin
                        burst_cnt <= burst_cnt - LW'(1);
                        remaining <= remaining - FW'(1);
                        if (burst_cnt == LW'(1)) begin
                            state <= (remaining == FW'(1)) ? DONE : WAIT_SPACE;
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write path: one register stage between an accepted DMA word and the SRAM write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_p1   <= 1'b0;
            wr_data_p1 <= '0;
        end else if (Reset) begin
            wr_en_p1   <= 1'b0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= vld_accept;
            if (vld_accept) begin
                wr_data_p1 <= DmaData;
            end
        end
    end

    // Write address persists across frames so the monitor's wrap tracking stays aligned
    gbf_addr_wrap #(
        .DEPTH (DEPTH)
    ) u_wr_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (Reset),
        .en    (wr_en_p1),
        .addr  (WrAddr)
    );

`ifdef GBF_FILL_ERR_EN
    // Sticky flag for DMA traffic arriving when no burst is expecting it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ErrOvf <= 1'b0;
        end else if (Reset) begin
            ErrOvf <= 1'b0;
        end else if ((DmaVld && !vld_accept) || (DmaAck && (state != REQ))) begin
            ErrOvf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gbf_fill_ctrl.sv
// Self-checking bench for gbf_fill_ctrl: table of directed frames, randomized
// frames against a burst/address reference model, and a mid-burst reset sequence.
module tb_gbf_fill_ctrl;
    import gbf_fill_pkg::*;

    localparam int TB_DEPTH = 128;
    localparam int TB_BURST = 32;

    logic                clk;
    logic                rst_n;
    logic                Reset;
    logic                Start;
    logic [15:0]         FrameWords;
    logic                ReqIn;
    logic                DmaReq;
    logic [LEN_W-1:0]    DmaLen;
    logic                DmaAck;
    logic                DmaVld;
    logic [63:0]         DmaData;
    logic                WrEn;
    logic [ADDR_W-1:0]   WrAddr;
    logic [63:0]         WrData;
    logic                Busy;
    logic                Done;
`ifdef GBF_FILL_ERR_EN
    logic                ErrOvf;
`endif

    gbf_fill_ctrl #(
        .DEPTH       (TB_DEPTH),
        .DATA_WIDTH  (64),
        .BURST_LEN   (TB_BURST),
        .FRAME_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Reset      (Reset),
        .Start      (Start),
        .FrameWords (FrameWords),
        .ReqIn      (ReqIn),
        .DmaReq     (DmaReq),
        .DmaLen     (DmaLen),
        .DmaAck     (DmaAck),
        .DmaVld     (DmaVld),
        .DmaData    (DmaData),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .Busy       (Busy),
        .Done       (Done)
`ifdef GBF_FILL_ERR_EN
        ,
        .ErrOvf     (ErrOvf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wr_t;

    typedef struct {
        int fw;
        int ack_dly;
        int reqin_low;
        bit gaps;
        bit start_recv;
        int exp_bursts;
        int exp_last_len;
        int exp_end_addr;
    } vec_t;

    int  n_pass;
    int  n_total;
    int  model_addr;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every SRAM write must match the next expected (addr, data)
    always @(negedge clk) begin
        if (rst_n && WrEn) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {57'd0, WrAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(WrAddr), 64'(e.addr));
                chk("wr_data", WrData, e.data);
            end
        end
    end

    // Drives one frame as the DMA side would; expectations come from the model queues
    task automatic run_frame(input int fw, input int ack_dly, input int reqin_low,
                             input bit gaps, input bit start_recv,
                             output int n_bursts, output int last_len);
        int          lens[$];
        logic [63:0] drv_q[$];
        int          rem;
        int          l;
        int          c;
        int          sent;
        bit          go;
        wr_t         w;
        n_bursts = 0;
        last_len = 0;
        rem = fw;
        while (rem > 0) begin
            l = (rem > TB_BURST) ? TB_BURST : rem;
            lens.push_back(l);
            rem -= l;
        end
        for (int i = 0; i < fw; i++) begin
            w.addr = ADDR_W'(model_addr);
            w.data = {$urandom, $urandom};
            exp_q.push_back(w);
            drv_q.push_back(w.data);
            model_addr = (model_addr + 1) % TB_DEPTH;
        end

        Start = 1'b1;
        FrameWords = 16'(fw);
        ReqIn = (reqin_low == 0);
        step();
        Start = 1'b0;

        if (fw == 0) begin
            @(negedge clk);
            chk("zero_done_early", 64'(Done), 64'(0));
            chk("zero_no_req_c1", 64'(DmaReq), 64'(0));
            step();
        end

        for (int b = 0; b < lens.size(); b++) begin
            if (b == 0 && reqin_low > 0) begin
                for (int i = 0; i < reqin_low; i++) begin
                    @(negedge clk);
                    chk("req_wait_space", 64'(DmaReq), 64'(0));
                    step();
                end
                ReqIn = 1'b1;
                step();
            end
            for (c = 0; c < 40; c++) begin
                @(negedge clk);
                if (DmaReq) break;
                step();
            end
            if (c >= 40) begin
                chk("req_timeout", 64'(c), 64'(0));
                exp_q.delete();
                return;
            end
            if (b == 0 && reqin_low > 0) chk("req_rise", 64'(c), 64'(0));
            n_bursts++;
            last_len = int'(DmaLen);
            chk("dma_len", 64'(DmaLen), 64'(lens[b]));
            for (int i = 0; i < ack_dly; i++) begin
                step();
                @(negedge clk);
                chk("req_hold", 64'(DmaReq), 64'(1));
                chk("len_hold", 64'(DmaLen), 64'(lens[b]));
            end
            DmaAck = 1'b1;
            step();
            DmaAck = 1'b0;

            sent = 0;
            while (sent < lens[b]) begin
                go = !gaps || ($urandom_range(0, 2) != 0);
                DmaVld  = go;
                DmaData = go ? drv_q.pop_front() : {$urandom, $urandom};
                DmaAck  = (gaps && !go) ? 1'($urandom_range(0, 1)) : 1'b0;
                ReqIn   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                Start   = start_recv && (b == 0) && (sent == 1);
                if (Start) FrameWords = 16'd3;
                if (sent == 0 && go) begin
                    @(negedge clk);
                    chk("req_drop", 64'(DmaReq), 64'(0));
                end
                step();
                if (go) sent++;
            end
            DmaVld = 1'b0;
            DmaAck = 1'b0;
            ReqIn  = 1'b1;
            Start  = 1'b0;
        end

        if (fw != 0) begin
            @(negedge clk);
            chk("done_early", 64'(Done), 64'(0));
            step();
        end
        @(negedge clk);
        chk("done_pulse", 64'(Done), 64'(1));
        chk("busy_at_done", 64'(Busy), 64'(0));
        if (fw == 0) chk("zero_no_req_c2", 64'(DmaReq), 64'(0));
        step();
        @(negedge clk);
        chk("done_single", 64'(Done), 64'(0));
        chk("writes_pending", 64'(exp_q.size()), 64'(0));
        step();
    endtask

    initial begin
        vec_t tbl[6];
        int   nb;
        int   ll;
        int   fw;
        int   exp_nb;
        int   c;
        wr_t  w;

        tbl[0] = '{64, 2, 0,  1'b0, 1'b0, 2, 32, 64};
        tbl[1] = '{40, 2, 0,  1'b0, 1'b0, 2, 8,  104};
        tbl[2] = '{16, 5, 10, 1'b0, 1'b0, 1, 16, 120};
        tbl[3] = '{16, 1, 0,  1'b0, 1'b0, 1, 16, 8};
        tbl[4] = '{0,  0, 0,  1'b0, 1'b0, 0, 0,  8};
        tbl[5] = '{33, 0, 0,  1'b1, 1'b1, 2, 1,  41};

        n_pass = 0;
        n_total = 0;
        model_addr = 0;
        rst_n = 1'b0;
        Reset = 1'b0;
        Start = 1'b0;
        FrameWords = '0;
        ReqIn = 1'b0;
        DmaAck = 1'b0;
        DmaVld = 1'b0;
        DmaData = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_dmareq", 64'(DmaReq), 64'(0));
        chk("rst_dmalen", 64'(DmaLen), 64'(0));
        chk("rst_wren",   64'(WrEn),   64'(0));
        chk("rst_wraddr", 64'(WrAddr), 64'(0));
        chk("rst_wrdata", WrData,      64'(0));
        chk("rst_busy",   64'(Busy),   64'(0));
        chk("rst_done",   64'(Done),   64'(0));
        step();

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].fw, tbl[i].ack_dly, tbl[i].reqin_low, tbl[i].gaps,
                      tbl[i].start_recv, nb, ll);
            chk("tbl_bursts",   64'(nb), 64'(tbl[i].exp_bursts));
            chk("tbl_last_len", 64'(ll), 64'(tbl[i].exp_last_len));
            @(negedge clk);
            chk("tbl_end_addr", 64'(WrAddr), 64'(tbl[i].exp_end_addr));
            step();
        end

        for (int r = 0; r < 6; r++) begin
            fw = $urandom_range(1, 100);
            exp_nb = (fw + TB_BURST - 1) / TB_BURST;
            run_frame(fw, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 1'b0, nb, ll);
            chk("rnd_bursts",   64'(nb), 64'(exp_nb));
            chk("rnd_last_len", 64'(ll), 64'(fw - TB_BURST * (exp_nb - 1)));
            @(negedge clk);
            chk("rnd_end_addr", 64'(WrAddr), 64'(model_addr));
            step();
        end

        // Mid-burst reset: 10 words land, then Reset, then 5 stray words
        Start = 1'b1;
        FrameWords = 16'd64;
        ReqIn = 1'b1;
        step();
        Start = 1'b0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (DmaReq) break;
            step();
        end
        chk("rst_seq_req", 64'(DmaReq), 64'(1));
        DmaAck = 1'b1;
        step();
        DmaAck = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w.addr = ADDR_W'(model_addr);
            w.data = {$urandom, $urandom};
            exp_q.push_back(w);
            model_addr = (model_addr + 1) % TB_DEPTH;
            DmaVld = 1'b1;
            DmaData = w.data;
            step();
        end
        DmaVld = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model_addr = 0;
        for (int i = 0; i < 5; i++) begin
            DmaVld = 1'b1;
            DmaData = {$urandom, $urandom};
            step();
        end
        DmaVld = 1'b0;
        @(negedge clk);
        chk("abort_busy",    64'(Busy),   64'(0));
        chk("abort_wraddr",  64'(WrAddr), 64'(0));
        chk("abort_wren",    64'(WrEn),   64'(0));
        chk("abort_dmareq",  64'(DmaReq), 64'(0));
        chk("abort_pending", 64'(exp_q.size()), 64'(0));
`ifdef GBF_FILL_ERR_EN
        chk("abort_errovf",  64'(ErrOvf), 64'(1));
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
